// File: rtl/motion_tracker_pkg.sv
// rtl/motion_tracker_pkg.sv - shared types and helpers for the motion tracker
package motion_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Tick period in clk cycles.
    function automatic int tick_period(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

    // Counter width for a given tick period. A period of 1 still needs a 1-bit counter.
    function automatic int tick_cnt_w(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    // Saturating position update: unsigned pos plus signed vel, clamped to [0, max_pos].
    // The sum carries two guard bits so overflow and underflow are both visible before clamping.
    function automatic logic [31:0] sat_add(input logic [31:0] pos,
                                            input logic [31:0] vel,
                                            input logic [31:0] max_pos);
        logic signed [33:0] sum;
        sum = $signed({2'b00, pos}) + $signed({vel[31], vel[31], vel});
        if (sum[33]) begin
            return 32'd0;
        end else if (sum > $signed({2'b00, max_pos})) begin
            return max_pos;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/motion_tracker_mc_tick_gen.sv
// rtl/motion_tracker_mc_tick_gen.sv - periodic single-cycle tick generator
module tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..PERIOD-1 while enabled; clear wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en && (cnt_q == LAST);

endmodule

// File: rtl/motion_tracker_mc.sv
// rtl/motion_tracker_mc.sv - multi-channel tick-driven position integrator
import motion_tracker_pkg::*;

module motion_tracker_mc #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int N_CH     = 4,
    parameter int POS_W    = 10,
    parameter int VEL_W    = 8,
    parameter int TIME_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [N_CH*POS_W-1:0]    start_pos_i,
    input  logic [N_CH*POS_W-1:0]    dest_pos_i,
    input  logic [N_CH*VEL_W-1:0]    start_vel_i,
    input  logic [N_CH*VEL_W-1:0]    vel_i,
    output logic                     busy_o,
    output logic [N_CH*POS_W-1:0]    pos_o,
    output logic [N_CH-1:0]          reached_o,
    output logic [N_CH*TIME_W-1:0]   reach_time_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     aborted_o
);

    localparam int TICK_P = tick_period(CLK_FREQ, TICK_HZ);
    localparam logic [31:0] POS_MAX = 32'((64'd1 << POS_W) - 64'd1);
    localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              aborted_q, aborted_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              tick;
    logic              do_load;
    logic              run_tick;
    logic [N_CH-1:0]   reached_vec;

    // Loading happens on the IDLE->LOAD edge so LOAD already shows the start values.
    assign do_load  = (state_q == IDLE) && start_i;
    // An abort freezes the channels even if it coincides with a tick.
    assign run_tick = (state_q == RUN) && tick && !abort_i;

    tick_gen #(
        .PERIOD (TICK_P)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == LOAD),
        .en     (state_q == RUN),
        .tick_o (tick)
    );

    // Sequencer next-state: abort beats all-reached beats timeout.
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD;
                    time_d    = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (run_tick) begin
                    time_d = time_q + 1'b1;
                end
                if (abort_i) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (&reached_vec) begin
                    state_d = DONE;
                end else if (time_q == TIME_MAX) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Sequencer registers with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            time_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
            time_q    <= time_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [POS_W-1:0]  pos_q, pos_d;
        logic [POS_W-1:0]  dest_q, dest_d;
        logic [POS_W-1:0]  pos_new;
        logic [VEL_W-1:0]  vel_q, vel_d;
        logic              dir_q, dir_d;
        logic              reach_q, reach_d;
        logic [TIME_W-1:0] rt_q, rt_d;
        logic              arrive;
        logic [POS_W-1:0]  sp;
        logic [POS_W-1:0]  dp;

        assign sp = start_pos_i[i*POS_W +: POS_W];
        assign dp = dest_pos_i[i*POS_W +: POS_W];

        assign pos_new = POS_W'(sat_add(32'(pos_q),
                                        {{(32-VEL_W){vel_q[VEL_W-1]}}, vel_q},
                                        POS_MAX));
        // Direction-aware arrival: moving up must reach or pass dest, moving down likewise.
        assign arrive = dir_q ? (pos_new >= dest_q) : (pos_new <= dest_q);

        // Channel next-state: load, or integrate one tick unless already arrived.
        always_comb begin
            pos_d   = pos_q;
            dest_d  = dest_q;
            vel_d   = vel_q;
            dir_d   = dir_q;
            reach_d = reach_q;
            rt_d    = rt_q;
            if (do_load) begin
                pos_d   = sp;
                dest_d  = dp;
                vel_d   = start_vel_i[i*VEL_W +: VEL_W];
                dir_d   = (sp <= dp);
                reach_d = (sp == dp);
                rt_d    = '0;
            end else if (run_tick && !reach_q) begin
                pos_d = pos_new;
                vel_d = vel_i[i*VEL_W +: VEL_W];
                if (arrive) begin
                    reach_d = 1'b1;
                    rt_d    = time_q + 1'b1;
                end
            end
        end

        // Channel registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pos_q   <= '0;
                dest_q  <= '0;
                vel_q   <= '0;
                dir_q   <= 1'b0;
                reach_q <= 1'b0;
                rt_q    <= '0;
            end else begin
                pos_q   <= pos_d;
                dest_q  <= dest_d;
                vel_q   <= vel_d;
                dir_q   <= dir_d;
                reach_q <= reach_d;
                rt_q    <= rt_d;
            end
        end

        assign pos_o[i*POS_W +: POS_W]         = pos_q;
        assign reach_time_o[i*TIME_W +: TIME_W] = rt_q;
        assign reached_vec[i]                   = reach_q;
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign aborted_o = aborted_q;
    assign reached_o = reached_vec;

endmodule

// File: tb/tb_motion_tracker_mc.sv
// tb/tb_motion_tracker_mc.sv - self-checking bench for motion_tracker_mc
module tb_motion_tracker_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [19:0] start_pos_i = '0;
    logic [19:0] dest_pos_i = '0;
    logic [15:0] start_vel_i = '0;
    logic [15:0] vel_i = '0;
    logic        busy_o;
    logic [19:0] pos_o;
    logic [1:0]  reached_o;
    logic [7:0]  reach_time_o;
    logic        done_o;
    logic        timeout_o;
    logic        aborted_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [9:0] sp0, sp1, dp0, dp1;
        logic [7:0] sv0, sv1, lv0, lv1;
        logic [9:0] ep0, ep1;
        logic [1:0] erch;
        logic [3:0] ert0, ert1;
        logic       eto;
    } vec_t;

    vec_t vecs[5];
    vec_t exp_q[$];

    motion_tracker_mc #(
        .CLK_FREQ (10),
        .TICK_HZ  (1),
        .N_CH     (2),
        .POS_W    (10),
        .VEL_W    (8),
        .TIME_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .start_pos_i  (start_pos_i),
        .dest_pos_i   (dest_pos_i),
        .start_vel_i  (start_vel_i),
        .vel_i        (vel_i),
        .busy_o       (busy_o),
        .pos_o        (pos_o),
        .reached_o    (reached_o),
        .reach_time_o (reach_time_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .aborted_o    (aborted_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
    end

    function automatic vec_t mk(input int sp0, input int sp1, input int dp0, input int dp1,
                                input int sv0, input int sv1, input int lv0, input int lv1,
                                input int ep0, input int ep1, input int erch,
                                input int ert0, input int ert1, input int eto);
        vec_t v;
        v.sp0 = 10'(sp0); v.sp1 = 10'(sp1); v.dp0 = 10'(dp0); v.dp1 = 10'(dp1);
        v.sv0 = 8'(sv0);  v.sv1 = 8'(sv1);  v.lv0 = 8'(lv0);  v.lv1 = 8'(lv1);
        v.ep0 = 10'(ep0); v.ep1 = 10'(ep1); v.erch = 2'(erch);
        v.ert0 = 4'(ert0); v.ert1 = 4'(ert1); v.eto = eto[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] pos_of(input int ch);
        return pos_o[ch*10 +: 10];
    endfunction

    function automatic logic [3:0] rt_of(input int ch);
        return reach_time_o[ch*4 +: 4];
    endfunction

    task automatic do_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (!done_o && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done_o), 32'd1);
    endtask

    task automatic wait_pos(input int ch, input int val, input int budget);
        int cyc = 0;
        while (pos_of(ch) != 10'(val) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("pos_reached_wait", 32'(pos_of(ch)), 32'(val));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        vec_t t;
        vec_t e;

        // forward, saturation+start==dest, underflow+live vel, overflow reach, all at dest
        vecs[0] = mk(0, 100, 20, 90, 5, -5, 5, -5, 20, 90, 3, 4, 2, 0);
        vecs[1] = mk(1020, 50, 5, 50, 10, 0, 10, 0, 1023, 50, 2, 0, 0, 1);
        vecs[2] = mk(8, 300, 0, 310, -3, 0, -10, 7, 0, 314, 3, 2, 3, 0);
        vecs[3] = mk(1000, 5, 1023, 0, 100, -1, 100, -1, 1023, 0, 3, 1, 5, 0);
        vecs[4] = mk(7, 9, 7, 9, 3, 3, 3, 3, 7, 9, 3, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_pos", 32'(pos_o), 0);
        check("rst_reached", 32'(reached_o), 0);
        check("rst_rtime", 32'(reach_time_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_aborted", 32'(aborted_o), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            t = vecs[v];
            start_pos_i = {t.sp1, t.sp0};
            dest_pos_i  = {t.dp1, t.dp0};
            start_vel_i = {t.sv1, t.sv0};
            vel_i       = {t.lv1, t.lv0};
            exp_q.push_back(t);
            dc = done_cnt;
            do_start();
            check("load_busy", 32'(busy_o), 1);
            check("load_reached", 32'(reached_o), 32'({t.sp1 == t.dp1, t.sp0 == t.dp0}));
            wait_done(400);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pos0", 32'(pos_of(0)), 32'(e.ep0));
                check("pos1", 32'(pos_of(1)), 32'(e.ep1));
                check("reached", 32'(reached_o), 32'(e.erch));
                check("rtime0", 32'(rt_of(0)), 32'(e.ert0));
                check("rtime1", 32'(rt_of(1)), 32'(e.ert1));
                check("timeout", 32'(timeout_o), 32'(e.eto));
                check("aborted", 32'(aborted_o), 0);
                check("busy_in_done", 32'(busy_o), 0);
            end
            @(negedge clk);
            check("done_width", 32'(done_o), 0);
            @(negedge clk);
            check("done_count", 32'(done_cnt - dc), 1);
        end

        // Abort at tick 3, with an ignored start pulse mid-run.
        start_pos_i = {10'd0, 10'd0};
        dest_pos_i  = {10'd1000, 10'd1000};
        start_vel_i = {8'd5, 8'd5};
        vel_i       = {8'd5, 8'd5};
        dc = done_cnt;
        do_start();
        wait_pos(0, 5, 100);
        start_pos_i = {10'd500, 10'd500};
        do_start();
        check("busy_start_ignored", 32'(busy_o), 1);
        wait_pos(0, 15, 100);
        check("abort_pre_pos1", 32'(pos_of(1)), 15);
        abort_i = 1'b1;
        @(negedge clk);
        check("abort_done", 32'(done_o), 1);
        check("abort_flag", 32'(aborted_o), 1);
        check("abort_timeout", 32'(timeout_o), 0);
        check("abort_pos0", 32'(pos_of(0)), 15);
        check("abort_busy", 32'(busy_o), 0);
        repeat (5) @(negedge clk);
        check("idle_abort_done_cnt", 32'(done_cnt - dc), 1);
        check("idle_abort_flag", 32'(aborted_o), 1);
        check("idle_abort_pos1", 32'(pos_of(1)), 15);
        check("idle_abort_busy", 32'(busy_o), 0);
        abort_i = 1'b0;

        // Reset mid-run at tick 2.
        start_pos_i = {10'd0, 10'd0};
        do_start();
        check("rerun_aborted_clr", 32'(aborted_o), 0);
        wait_pos(0, 10, 100);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_pos", 32'(pos_o), 0);
        check("mid_rst_reached", 32'(reached_o), 0);
        check("mid_rst_rtime", 32'(reach_time_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        @(negedge clk) rst = 1'b0;
        dc = done_cnt;
        repeat (30) @(negedge clk);
        check("post_rst_no_done", 32'(done_cnt - dc), 0);
        check("post_rst_busy", 32'(busy_o), 0);
        check("post_rst_pos", 32'(pos_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
